// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the ALU sequencer slice.
// Imported by the decoder and the sequencer top.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_NEG  = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_SHRA = 5'd9;
    localparam logic [4:0] OP_SHL  = 5'd10;
    localparam logic [4:0] OP_SHR  = 5'd11;
    localparam logic [4:0] OP_ROL  = 5'd12;
    localparam logic [4:0] OP_ROR  = 5'd13;
    localparam logic [4:0] OP_LAST = 5'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode classifier: legality and multi-cycle (mul/div) flag.
// Purely combinational.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [4:0] op,
    output logic       legal,
    output logic       is_muldiv
);

    assign legal     = (op != 5'd0) && (op <= OP_LAST);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle request/response controller wrapped around the 32-bit ALU.
// Latches operands, drives the ALU for a fixed time, captures the result.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_c,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] zhi,
    output logic [31:0] zlo,
    output logic        resp_err
);

    localparam logic [3:0] WAIT_LD = 4'(MULDIV_WAIT);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] y_a;
    logic [31:0] y_b;
    logic [4:0]  op_q;
    logic [3:0]  wait_cnt;
    logic        legal;
    logic        is_muldiv;

    alu_op_decode u_dec (
        .op        (req_op),
        .legal     (legal),
        .is_muldiv (is_muldiv)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid)
                    state_d = legal ? S_EXEC : S_RESP;
            end
            S_EXEC: begin
                if (wait_cnt == 4'd0)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_a      <= '0;
            y_b      <= '0;
            op_q     <= '0;
            wait_cnt <= '0;
            zhi      <= '0;
            zlo      <= '0;
            resp_err <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        y_a      <= req_a;
                        y_b      <= req_b;
                        op_q     <= req_op;
                        wait_cnt <= is_muldiv ? WAIT_LD : 4'd0;
                        // Illegal ops skip the ALU and report a zero result
                        if (!legal) begin
                            resp_err <= 1'b1;
                            zhi      <= '0;
                            zlo      <= '0;
                        end
                    end
                end
                S_EXEC: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        zhi      <= alu_c[63:32];
                        zlo      <= alu_c[31:0];
                        resp_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);

    // ALU sees zeros outside EXEC so it idles on its default path
    assign alu_a      = (state_q == S_EXEC) ? y_a  : '0;
    assign alu_b      = (state_q == S_EXEC) ? y_b  : '0;
    assign alu_opcode = (state_q == S_EXEC) ? op_q : '0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU.
// Immediate assertions at each comparison point.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(.MULDIV_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .zhi        (zhi),
        .zlo        (zlo),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_model(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  op
    );
        logic [63:0] r;
        r = 64'd0;
        case (op)
            5'd1:  r = {32'd0, a + b};
            5'd2:  r = {32'd0, a - b};
            5'd3:  r = {32'd0, a} * {32'd0, b};
            5'd4:  r = (b == 0) ? 64'd0 : {a % b, a / b};
            5'd12: r = {32'd0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
            5'd13: r = {32'd0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    always_comb alu_c = alu_model(alu_a, alu_b, alu_opcode);

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; return cycles to resp_valid and
    // number of cycles with a nonzero ALU opcode.
    task automatic run(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output int opc);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
        lat = 1;
        opc = 0;
        while (!resp_valid && lat < 40) begin
            if (alu_opcode != 5'd0) opc++;
            step();
            lat++;
        end
        check("resp_timeout", 64'(lat < 40), 64'd1);
    endtask

    int lat;
    int opc;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 5'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_zhi", 64'(zhi), 64'd0);
        check("rst_zlo", 64'(zlo), 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_alu_op", 64'(alu_opcode), 64'd0);
        reset = 1'b0;
        step();

        // ADD 5+7
        run(5'd1, 32'd5, 32'd7, lat, opc);
        check("add_lat", 64'(lat), 64'd2);
        check("add_opc_cycles", 64'(opc), 64'd1);
        check("add_zlo", 64'(zlo), 64'd12);
        check("add_zhi", 64'(zhi), 64'd0);
        check("add_err", 64'(resp_err), 64'd0);
        check("add_alu_idle", 64'(alu_opcode), 64'd0);
        step();
        check("add_back_idle", 64'(req_ready), 64'd1);
        check("add_valid_drop", 64'(resp_valid), 64'd0);

        // MUL 0x10000 * 0x10000
        run(5'd3, 32'h0001_0000, 32'h0001_0000, lat, opc);
        check("mul_lat", 64'(lat), 64'd6);
        check("mul_opc_cycles", 64'(opc), 64'd5);
        check("mul_zhi", 64'(zhi), 64'h1);
        check("mul_zlo", 64'(zlo), 64'h0);
        step();

        // SUB 3-5 with backpressure
        resp_ready = 1'b0;
        run(5'd2, 32'd3, 32'd5, lat, opc);
        check("sub_lat", 64'(lat), 64'd2);
        check("sub_zlo", 64'(zlo), 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sub_hold_valid", 64'(resp_valid), 64'd1);
            check("sub_hold_ready", 64'(req_ready), 64'd0);
            check("sub_hold_zlo", 64'(zlo), 64'hFFFF_FFFE);
        end
        resp_ready = 1'b1;
        step();
        check("sub_idle", 64'(req_ready), 64'd1);
        check("sub_valid_drop", 64'(resp_valid), 64'd0);

        // DIV 100/7 aborted by reset in the 2nd EXEC cycle
        req_valid = 1'b1;
        req_op    = 5'd4;
        req_a     = 32'd100;
        req_b     = 32'd7;
        step();
        req_valid = 1'b0;
        check("div_exec1_op", 64'(alu_opcode), 64'd4);
        step();
        check("div_exec2_op", 64'(alu_opcode), 64'd4);
        check("div_exec2_valid", 64'(resp_valid), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("div_rst_ready", 64'(req_ready), 64'd1);
        check("div_rst_valid", 64'(resp_valid), 64'd0);
        check("div_rst_zlo", 64'(zlo), 64'd0);
        check("div_rst_alu_op", 64'(alu_opcode), 64'd0);
        step();
        check("div_no_resp", 64'(resp_valid), 64'd0);
        run(5'd1, 32'd1, 32'd1, lat, opc);
        check("add11_zlo", 64'(zlo), 64'd2);
        step();

        // Illegal opcode
        run(5'b11111, 32'hDEAD_BEEF, 32'd0, lat, opc);
        check("ill_lat", 64'(lat), 64'd1);
        check("ill_opc_cycles", 64'(opc), 64'd0);
        check("ill_err", 64'(resp_err), 64'd1);
        check("ill_zhi", 64'(zhi), 64'd0);
        check("ill_zlo", 64'(zlo), 64'd0);
        check("ill_alu_op", 64'(alu_opcode), 64'd0);
        step();

        // Back-to-back ROL then ROR, request held high
        req_valid = 1'b1;
        req_op    = 5'd12;
        req_a     = 32'h8000_0001;
        req_b     = 32'd1;
        step();
        req_op = 5'd13;
        check("rol_exec_op", 64'(alu_opcode), 64'd12);
        step();
        check("rol_valid", 64'(resp_valid), 64'd1);
        check("rol_zlo", 64'(zlo), 64'h3);
        check("rol_err", 64'(resp_err), 64'd0);
        step();
        check("b2b_idle", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        check("ror_exec_op", 64'(alu_opcode), 64'd13);
        step();
        check("ror_valid", 64'(resp_valid), 64'd1);
        check("ror_zlo", 64'(zlo), 64'hC000_0000);
        step();
        check("ror_idle", 64'(req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
